// File: rtl/mc_result_collector.sv
// Collects per-core MC accumulators, sums/normalises/discounts them; oValid rises CoreN+2 edges after the last done.
// Holds oPrice/oValid until iAck; cores may deliver the next batch meanwhile (a second done per batch sets oOverrun).
module mc_result_collector #(
  parameter int CoreN     = 2,
  parameter int logCoreN  = 1,
  parameter int AccWidth  = 27,
  parameter int logPaths  = 10,
  parameter int DiscWidth = 18
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CoreN*AccWidth-1:0] iAcc,
  input  logic [CoreN-1:0]          iDone,
  input  logic [DiscWidth-1:0]      iDiscount,
  output logic [AccWidth-1:0]       oPrice,
  output logic                      oValid,
  input  logic                      iAck,
  output logic                      oBusy,
  output logic                      oOverrun,
  output logic [15:0]               oBatchCount
);

  localparam int SumW  = AccWidth + logCoreN;
  localparam int ProdW = AccWidth + DiscWidth;
  localparam logic [logCoreN-1:0] LastIdx = logCoreN'(CoreN - 1);

  typedef enum logic [1:0] {IDLE, SUM, SCALE, OUT} state_t;

  state_t                             state_q, state_d;
  logic [CoreN-1:0][AccWidth-1:0]     cap_q, cap_d;
  logic [CoreN-1:0]                   flag_q, flag_d;
  logic [SumW-1:0]                    sum_q, sum_d;
  logic [logCoreN-1:0]                idx_q, idx_d;
  logic [AccWidth-1:0]                price_q, price_d;
  logic                               valid_q, valid_d;
  logic                               overrun_q, overrun_d;
  logic [15:0]                        batch_cnt_q, batch_cnt_d;
  logic                               last_sum;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    flag_d      = flag_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    price_d     = price_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    batch_cnt_d = batch_cnt_q;
    last_sum    = (state_q == SUM) && (idx_q == LastIdx);

    // Flags clear on the final SUM edge, but a done landing on that same edge
    // belongs to the next batch and must survive the clear.
    if (last_sum) flag_d = '0;
    for (int i = 0; i < CoreN; i++) begin
      if (iDone[i]) begin
        if (!flag_q[i] || last_sum) begin
          cap_d[i]  = iAcc[i*AccWidth +: AccWidth];
          flag_d[i] = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        sum_d = '0;
        idx_d = '0;
        if (&flag_q) state_d = SUM;
      end
      SUM: begin
        sum_d = sum_q + SumW'(cap_q[idx_q]);
        idx_d = idx_q + logCoreN'(1);
        if (last_sum) state_d = SCALE;
      end
      SCALE: begin
        // Mean over all paths, then keep the integer.fraction alignment of the accumulator.
        price_d = AccWidth'(
          ({{DiscWidth{1'b0}}, AccWidth'(sum_q >> (logPaths + logCoreN))} *
           {{AccWidth{1'b0}}, iDiscount}) >> DiscWidth);
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (iAck) begin
          valid_d     = 1'b0;
          batch_cnt_d = batch_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      flag_q      <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      price_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      flag_q      <= flag_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      price_q     <= price_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

  assign oPrice      = price_q;
  assign oValid      = valid_q;
  assign oBusy       = (state_q != IDLE);
  assign oOverrun    = overrun_q;
  assign oBatchCount = batch_cnt_q;

  // ProdW documents the full multiplier width used inside SCALE.
  if (ProdW < AccWidth) begin : g_bad_width
    $error("mc_result_collector: DiscWidth must be non-negative");
  end

endmodule

// File: tb/tb_mc_result_collector.sv
// Directed bench for mc_result_collector: expected prices are queued when a batch is driven
// and popped when oValid is observed.
module tb_mc_result_collector;

  localparam int CoreN = 2;
  localparam int AccW  = 27;
  localparam int DiscW = 18;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [CoreN*AccW-1:0] iAcc;
  logic [CoreN-1:0]      iDone;
  logic [DiscW-1:0]      iDiscount;
  logic [AccW-1:0]       oPrice;
  logic                  oValid;
  logic                  iAck;
  logic                  oBusy;
  logic                  oOverrun;
  logic [15:0]           oBatchCount;

  int n_assert = 0;
  int n_fail   = 0;
  logic [AccW-1:0] exp_q[$];

  mc_result_collector dut (
    .CLK(CLK), .RST(RST), .iAcc(iAcc), .iDone(iDone), .iDiscount(iDiscount),
    .oPrice(oPrice), .oValid(oValid), .iAck(iAck), .oBusy(oBusy),
    .oOverrun(oOverrun), .oBatchCount(oBatchCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pop_price(input string tag);
    logic [AccW-1:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_price"}, 32'(oPrice), 32'(e));
    end
  endtask

  // Pulse dones for one cycle; idle slices carry junk since they must be ignored.
  task automatic done(input logic [1:0] mask, input logic [AccW-1:0] a0, input logic [AccW-1:0] a1);
    iDone = mask;
    iAcc  = {a1, a0};
    tick();
    iDone = '0;
    iAcc  = 54'({$urandom(), $urandom()});
  endtask

  // n edges after the reference edge oValid must rise, busy and not valid before that.
  task automatic expect_after(input string tag, input int n);
    for (int k = 1; k < n; k++) begin
      tick();
      chk({tag, "_early_valid"}, 32'(oValid), 32'd0);
      chk({tag, "_busy"}, 32'(oBusy), 32'd1);
    end
    tick();
    chk({tag, "_valid"}, 32'(oValid), 32'd1);
    pop_price(tag);
  endtask

  task automatic ack(input string tag);
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
    chk({tag, "_valid_drop"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; iAcc = '0; iDone = '0; iDiscount = '0; iAck = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(oValid), 32'd0);
    RST = 1'b0;
    tick();
    chk("rst_price", 32'(oPrice), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_overrun", 32'(oOverrun), 32'd0);
    chk("rst_count", 32'(oBatchCount), 32'd0);

    // Simultaneous dones: 1.0 mean discounted by 0.5.
    iDiscount = 18'h20000;
    exp_q.push_back(27'h0002000);
    done(2'b11, 27'h1000000, 27'h1000000);
    chk("t1_busy_capture_edge", 32'(oBusy), 32'd0);
    expect_after("t1", 4);

    // Consumer stalls for 20 cycles; output must not move.
    repeat (20) begin
      tick();
      chk("t3_hold_valid", 32'(oValid), 32'd1);
      chk("t3_hold_price", 32'(oPrice), 32'h0002000);
    end
    ack("t3");
    chk("t3_count", 32'(oBatchCount), 32'd1);
    chk("t3_idle", 32'(oBusy), 32'd0);

    // Staggered dones with a near-1.0 discount exercising truncation.
    iDiscount = 18'h3FFFF;
    repeat (8) tick();
    done(2'b01, 27'h0800000, 27'h7FFFFFF);
    for (int k = 0; k < 39; k++) begin
      tick();
      chk("t2_wait_valid", 32'(oValid), 32'd0);
    end
    chk("t2_wait_busy", 32'(oBusy), 32'd0);
    exp_q.push_back(27'h0003FFF);
    done(2'b10, 27'h7FFFFFF, 27'h1800000);
    expect_after("t2", 4);
    ack("t2");
    chk("t2_count", 32'(oBatchCount), 32'd2);

    // Core0 reports twice: first value is kept, overrun latches.
    iDiscount = 18'h20000;
    exp_q.push_back(27'h0000100);
    done(2'b01, 27'h0100000, 27'h0);
    chk("t4_no_overrun_yet", 32'(oOverrun), 32'd0);
    tick();
    done(2'b01, 27'h0200000, 27'h0);
    chk("t4_overrun", 32'(oOverrun), 32'd1);
    tick();
    done(2'b10, 27'h0, 27'h0000000);
    expect_after("t4", 4);
    chk("t4_overrun_sticky", 32'(oOverrun), 32'd1);

    // Reset while a result is pending.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_valid", 32'(oValid), 32'd0);
    chk("t6_count", 32'(oBatchCount), 32'd0);
    chk("t6_overrun", 32'(oOverrun), 32'd0);
    chk("t6_busy", 32'(oBusy), 32'd0);
    tick();
    chk("t6_idle_after", 32'(oBusy), 32'd0);

    // Batch A, with batch B's dones on A's last SUM edge, immediate acks.
    exp_q.push_back(27'h0002000);
    exp_q.push_back(27'h0001800);
    done(2'b11, 27'h1000000, 27'h1000000);
    tick();
    tick();
    iDone = 2'b11;
    iAcc  = {27'h0C00000, 27'h0C00000};
    tick();
    iDone = '0;
    iAcc  = '0;
    chk("t5a_early_valid", 32'(oValid), 32'd0);
    chk("t5a_busy", 32'(oBusy), 32'd1);
    tick();
    chk("t5a_valid", 32'(oValid), 32'd1);
    pop_price("t5a");
    ack("t5a");
    chk("t5a_count", 32'(oBatchCount), 32'd1);
    expect_after("t5b", 4);
    chk("t5b_no_overrun", 32'(oOverrun), 32'd0);
    ack("t5b");
    chk("t5b_count", 32'(oBatchCount), 32'd2);
    chk("t5b_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
